// File: rtl/writeback_stage.sv
// Writeback stage: retires MEM-stage instructions into the register file, waits for load data, and halts on HLT.
// Optional feature: define WB_LOAD_TIMEOUT_EN to abort a load after LOAD_TIMEOUT wait cycles (sets load_err).
module writeback_stage #(
    parameter int unsigned LOAD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_dst,
    input  logic        in_wen,
    input  logic        in_is_load,
    input  logic [15:0] in_alu_res,
    input  logic        in_halt,
    input  logic        mem_rd_valid,
    input  logic [15:0] mem_rd_data,
    output logic [3:0]  DstReg,
    output logic        WriteReg,
    output logic [15:0] DstData,
    output logic        halt_out,
    output logic [15:0] retire_cnt,
    output logic        load_err,
    output logic [1:0]  dbg_state
);

    // Handshake: an instruction transfers on a cycle where in_valid and in_ready are both high;
    // in_ready is high only in IDLE, and in_* is sampled only on that transfer.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        HALTED    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        wreg_q, wreg_d;
    logic [3:0]  dst_q, dst_d;
    logic [15:0] data_q, data_d;
    logic [3:0]  ld_dst_q, ld_dst_d;
    logic        ld_wen_q, ld_wen_d;
    logic        halt_q, halt_d;
    logic [15:0] retire_q, retire_d;

    if (LOAD_TIMEOUT < 1) begin : g_param_check
        $error("LOAD_TIMEOUT must be at least 1");
    end

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int unsigned CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    assign in_ready   = (state_q == IDLE);
    assign WriteReg   = wreg_q;
    assign DstReg     = dst_q;
    assign DstData    = data_q;
    assign halt_out   = halt_q;
    assign retire_cnt = retire_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d  = state_q;
        wreg_d   = 1'b0;
        dst_d    = dst_q;
        data_d   = data_q;
        ld_dst_d = ld_dst_q;
        ld_wen_d = ld_wen_q;
        halt_d   = halt_q;
        retire_d = retire_q;
`ifdef WB_LOAD_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // HLT takes priority over any other decoding of the same instruction.
                    if (in_halt) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                    end else if (in_is_load) begin
                        state_d  = LOAD_WAIT;
                        ld_dst_d = in_dst;
                        ld_wen_d = in_wen;
`ifdef WB_LOAD_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end else begin
                        wreg_d   = in_wen & (in_dst != 4'd0);
                        dst_d    = in_dst;
                        data_d   = in_alu_res;
                        retire_d = retire_q + 16'd1;
                    end
                end
            end
            LOAD_WAIT: begin
                if (mem_rd_valid) begin
                    state_d  = IDLE;
                    wreg_d   = ld_wen_q & (ld_dst_q != 4'd0);
                    dst_d    = ld_dst_q;
                    data_d   = mem_rd_data;
                    retire_d = retire_q + 16'd1;
                end
`ifdef WB_LOAD_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wreg_q   <= 1'b0;
            dst_q    <= 4'd0;
            data_q   <= 16'h0000;
            ld_dst_q <= 4'd0;
            ld_wen_q <= 1'b0;
            halt_q   <= 1'b0;
            retire_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            wreg_q   <= wreg_d;
            dst_q    <= dst_d;
            data_q   <= data_d;
            ld_dst_q <= ld_dst_d;
            ld_wen_q <= ld_wen_d;
            halt_q   <= halt_d;
            retire_q <= retire_d;
        end
    end

`ifdef WB_LOAD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU writes, loads, R0 suppression, halt, reset, retire wrap
// and (with WB_LOAD_TIMEOUT_EN) the load timeout.
module tb_writeback_stage;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 64;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_dst;
    logic        in_wen;
    logic        in_is_load;
    logic [15:0] in_alu_res;
    logic        in_halt;
    logic        mem_rd_valid;
    logic [15:0] mem_rd_data;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic        halt_out;
    logic [15:0] retire_cnt;
    logic        load_err;
    logic [1:0]  dbg_state;

    int tests_run;
    int tests_failed;
    logic [15:0] exp_retire;

    writeback_stage #(.LOAD_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dst       (in_dst),
        .in_wen       (in_wen),
        .in_is_load   (in_is_load),
        .in_alu_res   (in_alu_res),
        .in_halt      (in_halt),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .DstReg       (DstReg),
        .WriteReg     (WriteReg),
        .DstData      (DstData),
        .halt_out     (halt_out),
        .retire_cnt   (retire_cnt),
        .load_err     (load_err),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] dst, input logic wen,
                         input logic ld, input logic hlt, input logic [15:0] alu);
        in_valid   = v;
        in_dst     = dst;
        in_wen     = wen;
        in_is_load = ld;
        in_halt    = hlt;
        in_alu_res = alu;
    endtask

    task automatic idle_in();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
        mem_rd_valid = 1'b0;
        mem_rd_data  = 16'h0000;
    endtask

    task automatic check_write(input string tag, input logic we, input logic [3:0] dst, input logic [15:0] data);
        check_eq({tag, "_wen"}, {31'd0, WriteReg}, {31'd0, we});
        check_eq({tag, "_dst"}, {28'd0, DstReg}, {28'd0, dst});
        check_eq({tag, "_data"}, {16'd0, DstData}, {16'd0, data});
        check_eq({tag, "_retire"}, {16'd0, retire_cnt}, {16'd0, exp_retire});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wen"}, {31'd0, WriteReg}, 32'd0);
        check_eq({tag, "_dst"}, {28'd0, DstReg}, 32'd0);
        check_eq({tag, "_data"}, {16'd0, DstData}, 32'd0);
        check_eq({tag, "_halt"}, {31'd0, halt_out}, 32'd0);
        check_eq({tag, "_retire"}, {16'd0, retire_cnt}, 32'd0);
        check_eq({tag, "_lerr"}, {31'd0, load_err}, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_retire   = 16'h0000;
        idle_in();
        rst = 1'b0;
        #3;
        check_reset_outputs("reset");
        step();
        step();
        #2 rst = 1'b1;
        step();

        // ADD R3 <- 0x1234: write for exactly one cycle
        drive(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 16'h1234);
        step();
        idle_in();
        exp_retire = 16'd1;
        check_write("add_r3", 1'b1, 4'd3, 16'h1234);
        step();
        check_write("add_r3_after", 1'b0, 4'd3, 16'h1234);

        // back-to-back accepts, then a non-writing instruction
        drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0011);
        step();
        exp_retire = 16'd2;
        check_write("b2b_r1", 1'b1, 4'd1, 16'h0011);
        drive(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0022);
        step();
        exp_retire = 16'd3;
        check_write("b2b_r2", 1'b1, 4'd2, 16'h0022);
        drive(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 16'h0044);
        step();
        exp_retire = 16'd4;
        check_write("nowen_r4", 1'b0, 4'd4, 16'h0044);

        // write to R0 suppressed but retired
        drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h5555);
        step();
        idle_in();
        exp_retire = 16'd5;
        check_write("r0_write", 1'b0, 4'd0, 16'h5555);

        // stray load data in IDLE ignored
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'hDEAD;
        step();
        idle_in();
        check_write("stray_rd", 1'b0, 4'd0, 16'h5555);
        check_eq("stray_rd_ready", {31'd0, in_ready}, 32'd1);

        // load R5, data 3 cycles later; a waiting instruction must not be taken
        drive(1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 16'h0AAA);
        step();
        drive(1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 16'h7777);
        check_eq("ld_wait_ready0", {31'd0, in_ready}, 32'd0);
        check_write("ld_wait0", 1'b0, 4'd0, 16'h5555);
        for (int i = 1; i < 3; i++) begin
            step();
            check_eq("ld_wait_ready", {31'd0, in_ready}, 32'd0);
            check_eq("ld_wait_wen", {31'd0, WriteReg}, 32'd0);
        end
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'hBEEF;
        step();
        idle_in();
        exp_retire = 16'd6;
        check_write("ld_r5", 1'b1, 4'd5, 16'hBEEF);
        check_eq("ld_r5_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_write("ld_r5_after", 1'b0, 4'd5, 16'hBEEF);

        // load to R0: retired, no write
        drive(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        idle_in();
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'hC0DE;
        step();
        idle_in();
        exp_retire = 16'd7;
        check_write("ld_r0", 1'b0, 4'd0, 16'hC0DE);

`ifdef WB_LOAD_TIMEOUT_EN
        // load abandoned after TMO wait cycles
        drive(1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        idle_in();
        for (int i = 1; i < 4; i++) begin
            step();
            check_eq("tmo_wait_ready", {31'd0, in_ready}, 32'd0);
            check_eq("tmo_wait_lerr", {31'd0, load_err}, 32'd0);
        end
        step();
        check_eq("tmo_lerr", {31'd0, load_err}, 32'd1);
        check_eq("tmo_ready", {31'd0, in_ready}, 32'd1);
        check_write("tmo_nowrite", 1'b0, 4'd0, 16'hC0DE);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'h1111;
        step();
        idle_in();
        check_write("tmo_late_rd", 1'b0, 4'd0, 16'hC0DE);
        check_eq("tmo_lerr_sticky", {31'd0, load_err}, 32'd1);
`else
        // without the timeout a load waits indefinitely
        drive(1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        idle_in();
        repeat (70) step();
        check_eq("long_wait_ready", {31'd0, in_ready}, 32'd0);
        check_eq("long_wait_lerr", {31'd0, load_err}, 32'd0);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'h6666;
        step();
        idle_in();
        exp_retire = 16'd8;
        check_write("long_wait_ld", 1'b1, 4'd6, 16'h6666);
`endif

        // reset during LOAD_WAIT abandons the load
        drive(1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        idle_in();
        step();
        rst = 1'b0;
        #1;
        exp_retire = 16'd0;
        check_reset_outputs("rst_mid_load");
        #2 rst = 1'b1;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'h9999;
        step();
        idle_in();
        check_write("rst_late_rd", 1'b0, 4'd0, 16'h0000);
        check_eq("rst_late_ready", {31'd0, in_ready}, 32'd1);

        // retire counter wrap
        drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 16'h00AB);
        repeat (65535) step();
        exp_retire = 16'hFFFF;
        check_write("retire_ffff", 1'b1, 4'd1, 16'h00AB);
        step();
        idle_in();
        exp_retire = 16'h0000;
        check_write("retire_wrap", 1'b1, 4'd1, 16'h00AB);

        // HLT with in_valid held high afterwards
        drive(1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 16'h0BAD);
        step();
        drive(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0BAD);
        check_eq("halt_flag", {31'd0, halt_out}, 32'd1);
        check_eq("halt_ready", {31'd0, in_ready}, 32'd0);
        check_write("halt_nowrite", 1'b0, 4'd1, 16'h00AB);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'h4321;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("halted_ready", {31'd0, in_ready}, 32'd0);
            check_eq("halted_flag", {31'd0, halt_out}, 32'd1);
            check_write("halted_nowrite", 1'b0, 4'd1, 16'h00AB);
        end
        rst = 1'b0;
        #1;
        exp_retire = 16'd0;
        check_reset_outputs("halt_reset");
        idle_in();
        #2 rst = 1'b1;
        step();
        check_reset_outputs("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter LOAD_TIMEOUT, default 64, giving the maximum LOAD_WAIT cycles before abort (used only with WB_LOAD_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  MEM stage presents an instruction.
REQ-005 SHALL have port in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 SHALL have port in_dst  input  4  destination register index.
REQ-007 SHALL have port in_wen  input  1  instruction writes a register.
REQ-008 SHALL have port in_is_load  input  1  result comes from data memory.
REQ-009 SHALL have port in_alu_res  input  16  ALU/PC-derived result.
REQ-010 SHALL have port in_halt  input  1  instruction is HLT.
REQ-011 SHALL have port mem_rd_valid  input  1  load data valid from data memory.
REQ-012 SHALL have port mem_rd_data  input  16  load data.
REQ-013 SHALL have port DstReg  output  4  register-file write index.
REQ-014 SHALL have port WriteReg  output  1  register-file write enable.
REQ-015 SHALL have port DstData  output  16  register-file write data.
REQ-016 SHALL have port halt_out  output  1  sticky processor-halted flag.
REQ-017 SHALL have port retire_cnt  output  16  count of retired instructions.
REQ-018 SHALL have port load_err  output  1  sticky load-timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD_WAIT, HALTED; in_ready = (state==IDLE), combinational.
REQ-020 Accept = in_valid & in_ready; SHALL sample in_* only on accept.
REQ-021 Accepted non-load, non-halt: SHALL drive WriteReg=in_wen & (in_dst!=0), DstReg=in_dst, DstData=in_alu_res for exactly the following cycle; state stays IDLE (back-to-back accepts allowed, one write per cycle).
REQ-022 Accepted load: SHALL go to LOAD_WAIT, latching in_dst and in_wen; WriteReg=0 while waiting.
REQ-023 In LOAD_WAIT, on mem_rd_valid: SHALL drive WriteReg=wen_latched & (dst_latched!=0), DstData=mem_rd_data for the following cycle, return to IDLE.
REQ-024 mem_rd_valid in IDLE or HALTED SHALL be ignored (no write, no state change).
REQ-025 in_valid while in LOAD_WAIT or HALTED SHALL not be accepted (in_ready=0), even when mem_rd_valid is high the same cycle.
REQ-026 Accepted halt: SHALL go to HALTED, set halt_out=1 from the next cycle, no write; HALTED exits only by reset.
REQ-027 Writes to R0 SHALL be suppressed (WriteReg=0) but still counted as retired.
REQ-028 retire_cnt SHALL increment by 1 the cycle after each non-load/halt accept and the cycle after each load completion; wraps 16'hFFFF->16'h0000.
REQ-029 WriteReg SHALL be 0 in every cycle not named in REQ-021/REQ-023; DstReg/DstData hold last driven value.

Reset
REQ-030 On rst low, asynchronously: state=IDLE, WriteReg=0, DstReg=0, DstData=16'h0000, halt_out=0, retire_cnt=0, load_err=0, timeout counter=0.
REQ-031 Reset asserted mid-LOAD_WAIT SHALL abandon the load; a later mem_rd_valid SHALL not write.

Configuration
REQ-032 Macro WB_LOAD_TIMEOUT_EN defined: SHALL count LOAD_WAIT cycles; on reaching LOAD_TIMEOUT without mem_rd_valid SHALL set load_err=1 (sticky), return to IDLE with no write and no retire increment; counter clears on entering LOAD_WAIT.
REQ-033 Macro undefined: load_err tied 0, no counter, LOAD_WAIT waits indefinitely.

Verification
REQ-034 ADD to R3, in_alu_res=16'h1234 accepted cycle N -> WriteReg=1, DstReg=3, DstData=16'h1234 at N+1 only; retire_cnt=1.
REQ-035 Load to R5, mem_rd_valid with 16'hBEEF 3 cycles later -> in_ready=0 during wait, single write R5=16'hBEEF the cycle after, then in_ready=1.
REQ-036 Accept with in_dst=0, in_wen=1 -> WriteReg stays 0, retire_cnt increments.
REQ-037 HLT accepted then in_valid held high -> halt_out=1 next cycle, in_ready=0 forever, no further writes; rst low -> all outputs reset.
REQ-038 With WB_LOAD_TIMEOUT_EN, LOAD_TIMEOUT=4, load with no mem_rd_valid -> load_err=1 after 4 wait cycles, IDLE, no write; late mem_rd_valid ignored.
REQ-039 Preload retire_cnt to 16'hFFFF via 65535 retires, one more -> retire_cnt=16'h0000.
